// File: rtl/interp_rate_sched.sv
// Rate sequencer for a 2^RATIO_LOG2 interpolation chain: one-entry input buffer,
// per-period sample load into the filter, cascaded stage strobes, underrun and flush.
module interp_rate_sched #(
  parameter int RATIO_LOG2       = 7,
  parameter int NUM_STAGES       = 4,
  parameter int DW               = 16,
  parameter int FLUSH_PERIODS    = 8,
  parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clr_status,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DW-1:0]         s_data,
  output logic signed [DW-1:0]         filt_din,
  output logic [NUM_STAGES-1:0]        stage_stb,
  output logic [RATIO_LOG2-1:0]        phase,
  output logic                         running,
  output logic                         underrun,
  output logic [15:0]                  underrun_cnt
);

  localparam logic [RATIO_LOG2-1:0] CNT_MAX = '1;
  localparam int FW = (FLUSH_PERIODS > 0) ? $clog2(FLUSH_PERIODS + 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_PERIODS);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  state_t                   state, state_nxt;
  logic [RATIO_LOG2-1:0]    cnt, cnt_nxt;
  logic [FW-1:0]            flush_cnt, flush_cnt_nxt;
  logic                     buf_full, buf_full_nxt;
  logic signed [DW-1:0]     buf_data;
  logic signed [DW-1:0]     filt_nxt;
  logic [NUM_STAGES-1:0]    stb_nxt;
  logic                     xfer, wrap, active_nxt, load, underrun_evt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign s_ready = ((state == PRIME) || (state == RUN)) && !buf_full;
  assign xfer    = s_valid && s_ready;
  assign wrap    = (cnt == CNT_MAX);
  assign running = (state == RUN);
  assign phase   = cnt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME:   if (!enable) state_nxt = IDLE;
               else if (buf_full) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = FLUSH;
      FLUSH:   if (wrap && (flush_cnt == FLUSH_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next-cycle view: strobes and the load are registered so they line up with cnt
  always_comb begin
    cnt_nxt       = ((state == RUN) || (state == FLUSH)) ? cnt + 1'b1 : '0;
    active_nxt    = (state_nxt == RUN) || (state_nxt == FLUSH);
    load          = active_nxt && (cnt_nxt == '0);
    underrun_evt  = load && (state_nxt == RUN) && !buf_full;

    filt_nxt = filt_din;
    if (load) begin
      if (state_nxt == FLUSH)     filt_nxt = '0;
      else if (buf_full)          filt_nxt = buf_data;
      else if (!HOLD_ON_UNDERRUN) filt_nxt = '0;
    end

    buf_full_nxt = buf_full;
    if ((state_nxt == IDLE) || (state_nxt == FLUSH)) buf_full_nxt = 1'b0;
    else if (load && buf_full)                       buf_full_nxt = 1'b0;
    else if (xfer)                                   buf_full_nxt = 1'b1;

    flush_cnt_nxt = (state == FLUSH) ? flush_cnt : '0;
    if (load && (state_nxt == FLUSH)) flush_cnt_nxt = flush_cnt_nxt + 1'b1;

    for (int k = 0; k < NUM_STAGES; k++)
      stb_nxt[k] = active_nxt && ((cnt_nxt & (CNT_MAX >> k)) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      flush_cnt    <= '0;
      buf_full     <= 1'b0;
      stage_stb    <= '0;
      filt_din     <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      flush_cnt <= flush_cnt_nxt;
      buf_full  <= buf_full_nxt;
      stage_stb <= stb_nxt;
      filt_din  <= filt_nxt;
      // A fresh underrun wins over a simultaneous clear and restarts the count
      if (underrun_evt) begin
        underrun     <= 1'b1;
        underrun_cnt <= clr_status ? 16'd1 : sat_inc16(underrun_cnt);
      end else if (clr_status) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) buf_data <= s_data;
  end

endmodule

// File: tb/tb_interp_rate_sched.sv
// Scoreboard bench for interp_rate_sched: expected filter loads are queued as
// samples are offered and compared whenever stage_stb[0] marks a new period.
module tb_interp_rate_sched;

  logic               clk = 1'b0;
  logic               rst, enable, clr_status, s_valid;
  logic signed [15:0] s_data;
  logic               s_ready, running, underrun;
  logic signed [15:0] filt_din;
  logic [3:0]         stage_stb;
  logic [6:0]         phase;
  logic [15:0]        underrun_cnt;

  logic               s_ready_z, running_z, underrun_z;
  logic signed [15:0] filt_din_z;
  logic [3:0]         stage_stb_z;
  logic [6:0]         phase_z;
  logic [15:0]        underrun_cnt_z;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] sb[$];
  logic [15:0] last;

  always #5 clk = ~clk;

  interp_rate_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .filt_din(filt_din), .stage_stb(stage_stb), .phase(phase),
    .running(running), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  interp_rate_sched #(.HOLD_ON_UNDERRUN(1'b0)) dut_z (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
    .s_valid(s_valid), .s_ready(s_ready_z), .s_data(s_data),
    .filt_din(filt_din_z), .stage_stb(stage_stb_z), .phase(phase_z),
    .running(running_z), .underrun(underrun_z), .underrun_cnt(underrun_cnt_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && stage_stb[0]) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                chk("filt_din", filt_din, sb.pop_front());
    end
  end

  // Runs one full input period starting at a cnt==0 cycle in RUN
  task automatic run_period(input bit give, input logic [15:0] val, input int clr_at);
    int nz;
    int c[4];
    nz = 0;
    for (int k = 0; k < 4; k++) c[k] = 0;
    chk("run_running", running, 1);
    chk("run_phase0", phase, 0);
    if (!give) sb.push_back(last);
    for (int i = 0; i < 128; i++) begin
      s_valid = give && (i == 10);
      if (give && (i == 10)) begin
        s_data = val;
        sb.push_back(val);
        last = val;
      end
      clr_status = (i == clr_at);
      if (!s_ready) nz++;
      for (int k = 0; k < 4; k++) if (stage_stb[k]) c[k]++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    clr_status = 1'b0;
    chk("s_ready_low_cycles", nz, give ? 117 : 0);
    for (int k = 0; k < 4; k++) chk("stb_count", c[k], 32'(1) << k);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0, nr;
    rst = 1'b1; enable = 1'b0; clr_status = 1'b0; s_valid = 1'b0; s_data = '0;
    tick(3);
    chk("rst_filt", filt_din, 0);
    chk("rst_stb", stage_stb, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_running", running, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ucnt", underrun_cnt, 0);
    rst = 1'b0;

    // Priming with no sample available
    enable = 1'b1;
    tick(20);
    chk("prime_stb", stage_stb, 0);
    chk("prime_ready", s_ready, 1);
    chk("prime_filt", filt_din, 0);
    chk("prime_running", running, 0);

    // First sample starts the run
    s_valid = 1'b1; s_data = 16'sd100; sb.push_back(16'd100); last = 16'd100;
    tick(1);
    s_valid = 1'b0;
    chk("prime_full_ready", s_ready, 0);
    chk("prime_full_running", running, 0);
    tick(1);
    chk("run_start_running", running, 1);
    chk("run_start_phase", phase, 0);
    chk("run_start_stb", stage_stb, 4'hF);

    // Steady stream
    run_period(1'b1, 16'd1, -1);
    run_period(1'b1, 16'd2, -1);
    run_period(1'b1, 16'd3, -1);
    run_period(1'b1, 16'd500, -1);
    chk("stream_underrun", underrun, 0);
    chk("stream_ucnt", underrun_cnt, 0);
    chk("hold0_pre", filt_din_z, 500);

    // Underrun with hold, and zero substitution on the other instance
    run_period(1'b0, 16'd0, -1);
    chk("ur_flag", underrun, 1);
    chk("ur_cnt", underrun_cnt, 1);
    chk("ur_hold0_filt", filt_din_z, 0);
    run_period(1'b1, 16'd7, -1);
    chk("ur_sticky", underrun, 1);
    chk("ur_sticky_cnt", underrun_cnt, 1);
    run_period(1'b0, 16'd0, 127);
    chk("ur_clr_coinc_flag", underrun, 1);
    chk("ur_clr_coinc_cnt", underrun_cnt, 1);
    run_period(1'b1, 16'd8, 50);
    chk("clr_flag", underrun, 0);
    chk("clr_cnt", underrun_cnt, 0);

    // Disable with a sample buffered: discarded, then eight zero loads
    for (int i = 0; i < 60; i++) begin
      s_valid = (i == 10);
      s_data = 16'sd9;
      @(negedge clk);
    end
    s_valid = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) sb.push_back(16'd0);
    tick(1);
    chk("flush_ready", s_ready, 0);
    chk("flush_running", running, 0);
    t = 0; n0 = 0; nr = 0;
    while (!((phase == 0) && (stage_stb == 0)) && (t < 3000)) begin
      if (stage_stb[0]) n0++;
      if (s_ready) nr++;
      enable = (t >= 300) && (t < 304);
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    chk("flush_len", t, 1091);
    chk("flush_loads", n0, 8);
    chk("flush_ready_cycles", nr, 0);
    chk("flush_idle_running", running, 0);

    // Reset in RUN at cnt=37 after an underrun
    enable = 1'b1; s_valid = 1'b1; s_data = 16'sd11; sb.push_back(16'd11); last = 16'd11;
    tick(2);
    s_valid = 1'b0;
    tick(1);
    chk("r6_running", running, 1);
    run_period(1'b0, 16'd0, -1);
    chk("r6_underrun", underrun, 1);
    tick(37);
    chk("r6_phase37", phase, 37);
    rst = 1'b1; enable = 1'b0;
    tick(1);
    chk("r6_filt", filt_din, 0);
    chk("r6_stb", stage_stb, 0);
    chk("r6_ready", s_ready, 0);
    chk("r6_running_off", running, 0);
    chk("r6_underrun_off", underrun, 0);
    chk("r6_ucnt", underrun_cnt, 0);
    chk("r6_phase", phase, 0);
    rst = 1'b0;

    // Reset during FLUSH: no flush completes
    enable = 1'b1; s_valid = 1'b1; s_data = 16'sd12; sb.push_back(16'd12); last = 16'd12;
    tick(2);
    s_valid = 1'b0;
    tick(1);
    chk("rf_running", running, 1);
    tick(5);
    enable = 1'b0;
    tick(1);
    chk("rf_flush_running", running, 0);
    chk("rf_flush_ready", s_ready, 0);
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("rf_filt", filt_din, 0);
    chk("rf_stb", stage_stb, 0);
    chk("rf_phase", phase, 0);
    chk("rf_ready", s_ready, 0);
    rst = 1'b0;
    tick(5);
    chk("rf_idle_stb", stage_stb, 0);
    chk("rf_idle_running", running, 0);
    chk("sb_leftover", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
